// File: rtl/pipe_share_pkg.sv
// Shared types and helpers for the shared fixed-latency pipeline scheduler.
// Optional statistics are enabled with PIPE_SHARE_SCHED_STATS_EN.
package pipe_share_pkg;

  localparam int STAT_W = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_share_rr_arb.sv
// Round-robin arbiter: searches upward from the last grant, with wrap.
// The pointer moves to the granted index only when upd_i is set.
module pipe_share_rr_arb
  import pipe_share_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = id_w(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_i,
  input  logic             en_i,
  input  logic             upd_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o
);

  logic [IW-1:0] ptr_q;
  logic          hit;
  int            j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    hit   = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(ptr_q) + k) % N_REQ;
      if (en_i && !hit && req_i[j]) begin
        hit      = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
  end

  // Reset to the last index so requester 0 is first in line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= IW'(N_REQ - 1);
    end else if (upd_i) begin
      ptr_q <= idx_o;
    end
  end

endmodule

// File: rtl/pipe_share_sched.sv
// Shares one non-stallable fixed-latency pipeline between N_REQ requesters.
// Optional per-requester/stall counters under PIPE_SHARE_SCHED_STATS_EN.
module pipe_share_sched
  import pipe_share_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 32,
  parameter int LATENCY = 3,
  parameter int DEPTH   = 8,
  localparam int IW = id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               pipe_in_valid,
  output logic [W-1:0]       pipe_in_data,
  input  logic [W-1:0]       pipe_out_data,
  output logic               resp_valid,
  output logic [W-1:0]       resp_data,
  output logic [IW-1:0]      resp_id,
  input  logic               resp_ready,
  output logic               busy
`ifdef PIPE_SHARE_SCHED_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] issue_cnt,
  output logic [STAT_W-1:0]       stall_cnt
`endif
);

  localparam int PW = id_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(LATENCY + 1);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] id;
  } shadow_t;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gidx;
  logic             can_issue;
  logic             issue;
  logic             capture;
  logic             full;
  logic             push_ok;
  logic             pop;

  logic [FW-1:0] infl_q, infl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;

  shadow_t [LATENCY-1:0] sh_q;

  logic [W-1:0]  fifo_data [DEPTH];
  logic [IW-1:0] fifo_id   [DEPTH];

  // Credit covers both in-flight and buffered results, so capture never overflows.
  assign can_issue = (32'(infl_q) + 32'(cnt_q)) < 32'(DEPTH);

  pipe_share_rr_arb #(
    .N_REQ(N_REQ)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req_i(req_valid),
    .en_i (can_issue && rst),
    .upd_i(issue),
    .gnt_o(gnt),
    .idx_o(gidx)
  );

  assign issue         = |gnt;
  assign req_ready     = gnt;
  assign pipe_in_valid = issue;
  assign pipe_in_data  = req_data[int'(gidx)*W +: W];

  assign capture = sh_q[LATENCY-1].valid;
  assign full    = (cnt_q == CW'(DEPTH));
  assign push_ok = capture && !full;

  assign resp_valid = (cnt_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = resp_valid ? fifo_data[rp_q] : '0;
  assign resp_id    = resp_valid ? fifo_id[rp_q] : '0;

  assign busy = (infl_q != '0) || (cnt_q != '0) || issue;

  always_comb begin
    infl_d = infl_q;
    if (issue && !capture) begin
      infl_d = infl_q + 1'b1;
    end else if (!issue && capture) begin
      infl_d = infl_q - 1'b1;
    end
    cnt_d = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    wp_d = wp_q;
    if (push_ok) begin
      wp_d = (wp_q == PW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    end
    rp_d = rp_q;
    if (pop) begin
      rp_d = (rp_q == PW'(DEPTH - 1)) ? '0 : rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      infl_q <= '0;
      cnt_q  <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      sh_q   <= '0;
    end else begin
      infl_q <= infl_d;
      cnt_q  <= cnt_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      sh_q[0] <= {issue, gidx};
      for (int k = 1; k < LATENCY; k++) begin
        sh_q[k] <= sh_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_data[wp_q] <= pipe_out_data;
      fifo_id[wp_q]   <= sh_q[LATENCY-1].id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && capture) begin
      assert (!full) else $error("pipe_share_sched: capture into full FIFO dropped");
    end
  end

`ifdef PIPE_SHARE_SCHED_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] icnt_q;
  logic [STAT_W-1:0]            stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      icnt_q  <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i] && (icnt_q[i] != '1)) begin
          icnt_q[i] <= icnt_q[i] + 1'b1;
        end
      end
      if ((|req_valid) && !can_issue && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign issue_cnt = icnt_q;
  assign stall_cnt = stall_q;
`endif

endmodule
